// File: rtl/can_rx_if.sv
// Receive-side result bundle of can_rx: decoded frame fields, status pulses,
// ACK request and busy flag.
interface can_rx_if;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [2:0]  error_code;
    logic        ack_out;
    logic        busy;

    modport master (
        output rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, rx_error,
               error_code, ack_out, busy
    );

    modport slave (
        input rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, rx_error,
              error_code, ack_out, busy
    );
endinterface

// File: rtl/can_rx.sv
// CAN 2.0A receiver: bus integration, destuffing, standard frame parsing, CRC-15 check.
// Optional acceptance filter on rx_id == address enabled by `define CAN_RX_FILTER_EN.
module can_rx #(
    parameter int MAX_BYTES = 4,
    parameter int IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        CAN_RX,
    input  logic [10:0] address,
    can_rx_if.master    rx
);
    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic [3:0] {
        ST_INTEGRATE, ST_IDLE, ST_ARB, ST_CTRL, ST_DATA, ST_CRC,
        ST_CRC_DELIM, ST_ACK_SLOT, ST_ACK_DELIM, ST_EOF
    } state_t;

    state_t      state;
    logic        s;
    logic [IW-1:0] idle_cnt;
    logic [2:0]  stuff_cnt;
    logic        stuff_last;
    logic [14:0] crc;
    logic [14:0] crc_rx;
    logic [5:0]  bit_cnt;
    logic [10:0] id_sh;
    logic        rtr_r;
    logic [3:0]  dlc_r;
    logic [31:0] data_sh;

    logic        destuff, is_stuff, err, filter_ok;
    logic [2:0]  err_code;
    logic [3:0]  dlc_full;
    logic [14:0] crc_nxt;
    logic [31:0] data_aligned;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
    endfunction

`ifdef CAN_RX_FILTER_EN
    assign filter_ok = (id_sh == address);
`else
    logic unused_address;
    assign filter_ok      = 1'b1;
    assign unused_address = ^address;
`endif

    assign destuff  = (state == ST_ARB) || (state == ST_CTRL) ||
                      (state == ST_DATA) || (state == ST_CRC);
    assign is_stuff = destuff && (stuff_cnt == 3'd5);
    assign dlc_full = {dlc_r[2:0], s};
    assign crc_nxt  = crc_step(crc, s);

    // A stuff-bit violation masks every field check of the same bit.
    always_comb begin
        err      = 1'b0;
        err_code = 3'd0;
        if (is_stuff && (s == stuff_last)) begin
            err      = 1'b1;
            err_code = 3'd1;
        end else if (!is_stuff) begin
            case (state)
                ST_CTRL: begin
                    if (bit_cnt == 6'd0 && s) begin
                        err      = 1'b1;
                        err_code = 3'd4;
                    end else if (bit_cnt == 6'd5 && dlc_full > 4'(MAX_BYTES)) begin
                        err      = 1'b1;
                        err_code = 3'd2;
                    end
                end
                ST_CRC_DELIM: begin
                    if (!s) begin
                        err      = 1'b1;
                        err_code = 3'd2;
                    end else if (crc_rx != crc) begin
                        err      = 1'b1;
                        err_code = 3'd3;
                    end
                end
                ST_ACK_DELIM, ST_EOF: begin
                    if (!s) begin
                        err      = 1'b1;
                        err_code = 3'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data bits arrive right-justified in data_sh; byte0 goes to [31:24].
    always_comb begin
        case (dlc_r)
            4'd0:    data_aligned = 32'h0;
            4'd1:    data_aligned = {data_sh[7:0], 24'h0};
            4'd2:    data_aligned = {data_sh[15:0], 16'h0};
            4'd3:    data_aligned = {data_sh[23:0], 8'h0};
            default: data_aligned = data_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state         <= ST_INTEGRATE;
            s             <= 1'b1;
            idle_cnt      <= '0;
            stuff_cnt     <= 3'd0;
            stuff_last    <= 1'b0;
            crc           <= 15'h0;
            crc_rx        <= 15'h0;
            bit_cnt       <= 6'd0;
            id_sh         <= 11'h0;
            rtr_r         <= 1'b0;
            dlc_r         <= 4'h0;
            data_sh       <= 32'h0;
            rx.rx_id      <= 11'h0;
            rx.rx_rtr     <= 1'b0;
            rx.rx_dlc     <= 4'h0;
            rx.rx_data    <= 32'h0;
            rx.rx_valid   <= 1'b0;
            rx.rx_error   <= 1'b0;
            rx.error_code <= 3'd0;
            rx.ack_out    <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            s           <= CAN_RX;
            rx.rx_valid <= 1'b0;
            rx.rx_error <= 1'b0;
            if (err) begin
                rx.rx_error   <= 1'b1;
                rx.error_code <= err_code;
                rx.busy       <= 1'b0;
                rx.ack_out    <= 1'b0;
                idle_cnt      <= '0;
                state         <= ST_INTEGRATE;
            end else begin
                if (destuff) begin
                    if (is_stuff || s != stuff_last) begin
                        stuff_cnt  <= 3'd1;
                        stuff_last <= s;
                    end else begin
                        stuff_cnt <= stuff_cnt + 3'd1;
                    end
                end
                case (state)
                    ST_INTEGRATE: begin
                        if (!s) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IW'(IDLE_BITS - 1)) begin
                            idle_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (!s) begin
                            rx.busy    <= 1'b1;
                            stuff_cnt  <= 3'd1;
                            stuff_last <= 1'b0;
                            crc        <= crc_step(15'h0, s);
                            bit_cnt    <= 6'd0;
                            id_sh      <= 11'h0;
                            rtr_r      <= 1'b0;
                            dlc_r      <= 4'h0;
                            data_sh    <= 32'h0;
                            state      <= ST_ARB;
                        end
                    end
                    ST_ARB: if (!is_stuff) begin
                        crc <= crc_nxt;
                        if (bit_cnt < 6'd11) begin
                            id_sh   <= {id_sh[9:0], s};
                            bit_cnt <= bit_cnt + 6'd1;
                        end else begin
                            rtr_r   <= s;
                            bit_cnt <= 6'd0;
                            state   <= ST_CTRL;
                        end
                    end
                    ST_CTRL: if (!is_stuff) begin
                        crc <= crc_nxt;
                        if (bit_cnt >= 6'd2) dlc_r <= dlc_full;
                        if (bit_cnt == 6'd5) begin
                            bit_cnt <= 6'd0;
                            state   <= (rtr_r || dlc_full == 4'd0) ? ST_CRC : ST_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_DATA: if (!is_stuff) begin
                        crc     <= crc_nxt;
                        data_sh <= {data_sh[30:0], s};
                        if (bit_cnt == {dlc_r[2:0], 3'b000} - 6'd1) begin
                            bit_cnt <= 6'd0;
                            state   <= ST_CRC;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_CRC: if (!is_stuff) begin
                        crc_rx <= {crc_rx[13:0], s};
                        if (bit_cnt == 6'd14) begin
                            bit_cnt <= 6'd0;
                            state   <= ST_CRC_DELIM;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_CRC_DELIM: begin
                        rx.ack_out <= filter_ok;
                        state      <= ST_ACK_SLOT;
                    end
                    ST_ACK_SLOT: begin
                        rx.ack_out <= 1'b0;
                        state      <= ST_ACK_DELIM;
                    end
                    ST_ACK_DELIM: begin
                        bit_cnt <= 6'd0;
                        state   <= ST_EOF;
                    end
                    ST_EOF: begin
                        if (bit_cnt == 6'd6) begin
                            rx.busy <= 1'b0;
                            state   <= ST_IDLE;
                            if (filter_ok) begin
                                rx.rx_valid <= 1'b1;
                                rx.rx_id    <= id_sh;
                                rx.rx_rtr   <= rtr_r;
                                rx.rx_dlc   <= dlc_r;
                                rx.rx_data  <= data_aligned;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    default: state <= ST_INTEGRATE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_can_rx.sv
// Bench for can_rx: builds stuffed CAN frames with a reference CRC-15 and
// scores rx_valid / rx_error events and ack_out timing against queued expectations.
module tb_can_rx;
    logic        clk = 1'b0;
    logic        RESET;
    logic        CAN_RX;
    logic [10:0] address;

    can_rx_if rx();

    can_rx dut (
        .clk     (clk),
        .RESET   (RESET),
        .CAN_RX  (CAN_RX),
        .address (address),
        .rx      (rx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        int          at;
        logic [2:0]  code;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int bit_idx = 0;
    int ack_cnt = 0;
    int ack_at  = -1;
    int busy_cnt = 0;
    logic [10:0] last_id   = 11'h0;
    logic        last_rtr  = 1'b0;
    logic [3:0]  last_dlc  = 4'h0;
    logic [31:0] last_data = 32'h0;

    bit raw[$];
    bit fq[$];
    int map[$];
    int delim_rel, eof1_rel, eof7_rel;

    function automatic logic [14:0] crc_of(input int n);
        logic [14:0] c;
        logic        fb;
        c = 15'h0;
        for (int i = 0; i < n; i++) begin
            fb = raw[i] ^ c[14];
            c  = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    // Field bits SOF..CRC, then stuffing (no stuff bit after the last CRC bit), then tail.
    task automatic build_frame(input logic [10:0] id, input bit rtr, input bit ide,
                               input logic [3:0] dlc, input logic [31:0] data, input int flip);
        int nb, run;
        logic [14:0] c;
        bit last;
        raw.delete(); fq.delete(); map.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = (rtr || dlc > 4) ? 0 : int'(dlc);
        for (int i = 31; i >= 32 - 8 * nb; i--) raw.push_back(data[i]);
        c = crc_of(raw.size());
        if (flip >= 0) raw[flip] = ~raw[flip];
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        run = 0;
        last = 1'b0;
        for (int i = 0; i < raw.size(); i++) begin
            fq.push_back(raw[i]);
            map.push_back(fq.size() - 1);
            if (i == 0 || raw[i] != last) run = 1; else run++;
            last = raw[i];
            if (run == 5 && i < raw.size() - 1) begin
                fq.push_back(~raw[i]);
                last = ~raw[i];
                run = 1;
            end
        end
        delim_rel = fq.size();
        fq.push_back(1'b1);
        fq.push_back(1'b1);
        fq.push_back(1'b1);
        eof1_rel = fq.size();
        for (int i = 0; i < 7; i++) fq.push_back(1'b1);
        eof7_rel = fq.size() - 1;
    endtask

    function automatic void push_valid(input int at, input logic [10:0] id, input logic rtr,
                                       input logic [3:0] dlc, input logic [31:0] data);
        exp_t e;
        logic [31:0] m;
        m = (dlc >= 4) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> (8 * dlc));
        if (rtr) m = 32'h0;
        e.is_err = 1'b0; e.at = at; e.code = 3'd0;
        e.id = id; e.rtr = rtr; e.dlc = dlc; e.data = data & m;
        sb.push_back(e);
        last_id = id; last_rtr = rtr; last_dlc = dlc; last_data = data & m;
    endfunction

    function automatic void push_error(input int at, input logic [2:0] code);
        exp_t e;
        e.is_err = 1'b1; e.at = at; e.code = code;
        e.id = last_id; e.rtr = last_rtr; e.dlc = last_dlc; e.data = last_data;
        sb.push_back(e);
    endfunction

    // Outputs seen at this negedge were produced by the bit driven two bits ago.
    task automatic observe();
        exp_t e;
        int obs;
        obs = bit_idx - 2;
        if (rx.ack_out) begin ack_cnt++; ack_at = obs; end
        if (rx.busy) busy_cnt++;
        if (rx.rx_valid || rx.rx_error) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event valid=%0b error=%0b bit=%0d, required none",
                         rx.rx_valid, rx.rx_error, obs);
            end else begin
                e = sb.pop_front();
                if (rx.rx_error !== e.is_err || rx.rx_valid !== !e.is_err || obs != e.at) begin
                    bad++;
                    $display("FAIL event_kind got err=%0b val=%0b bit=%0d, required err=%0b bit=%0d",
                             rx.rx_error, rx.rx_valid, obs, e.is_err, e.at);
                end
                total++;
                if ({rx.rx_id, rx.rx_rtr, rx.rx_dlc, rx.rx_data} !== {e.id, e.rtr, e.dlc, e.data}) begin
                    bad++;
                    $display("FAIL rx_fields got id=%h rtr=%0b dlc=%0d data=%h, required id=%h rtr=%0b dlc=%0d data=%h",
                             rx.rx_id, rx.rx_rtr, rx.rx_dlc, rx.rx_data, e.id, e.rtr, e.dlc, e.data);
                end
                if (e.is_err) begin
                    total++;
                    if (rx.error_code !== e.code) begin
                        bad++;
                        $display("FAIL error_code got=%0d required=%0d", rx.error_code, e.code);
                    end
                end
            end
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        observe();
        CAN_RX = b;
        bit_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_fq();
        for (int i = 0; i < fq.size(); i++) send_bit(fq[i]);
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_events got pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; CAN_RX = 1'b1; address = 11'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({rx.rx_id, rx.rx_rtr, rx.rx_dlc, rx.rx_data} !== 48'h0) begin
            bad++; $display("FAIL reset_fields got id=%h data=%h required 0", rx.rx_id, rx.rx_data);
        end
        total++;
        if ({rx.rx_valid, rx.rx_error, rx.error_code, rx.ack_out, rx.busy} !== 7'h0) begin
            bad++; $display("FAIL reset_status got v=%0b e=%0b code=%0d ack=%0b busy=%0b required 0",
                            rx.rx_valid, rx.rx_error, rx.error_code, rx.ack_out, rx.busy);
        end
        RESET = 1'b0;
    endtask

    task automatic test_integration();
        int base;
        busy_cnt = 0; ack_cnt = 0;
        address = 11'h7A0;
        idle(5);
        send_bit(1'b0);
        idle(11);
        total++;
        if (busy_cnt != 0) begin
            bad++; $display("FAIL integ_ignore_sof got busy_cycles=%0d required=0", busy_cnt);
        end
        build_frame(11'h7A0, 1'b1, 1'b0, 4'd3, 32'h0, -1);
        base = bit_idx;
        push_valid(base + eof7_rel, 11'h7A0, 1'b1, 4'd3, 32'h0);
        send_fq();
        idle(4);
        total++;
        if (busy_cnt != eof7_rel) begin
            bad++; $display("FAIL integ_busy got=%0d required=%0d", busy_cnt, eof7_rel);
        end
        total++;
        if (ack_cnt != 1) begin
            bad++; $display("FAIL integ_ack got=%0d required=1", ack_cnt);
        end
        check_drained("integ");
    endtask

    task automatic test_good_frame();
        int base;
        address = 11'h025;
        idle(11);
        build_frame(11'h025, 1'b0, 1'b0, 4'd2, 32'hA53C_0000, -1);
        base = bit_idx;
        push_valid(base + eof7_rel, 11'h025, 1'b0, 4'd2, 32'hA53C_0000);
        ack_cnt = 0; busy_cnt = 0; ack_at = -1;
        send_fq();
        idle(4);
        total++;
        if (ack_cnt != 1 || ack_at != base + delim_rel) begin
            bad++; $display("FAIL good_ack got count=%0d at=%0d required count=1 at=%0d",
                            ack_cnt, ack_at, base + delim_rel);
        end
        total++;
        if (busy_cnt != eof7_rel) begin
            bad++; $display("FAIL good_busy got=%0d required=%0d", busy_cnt, eof7_rel);
        end
        check_drained("good");
    endtask

    task automatic test_back_to_back();
        int base;
        ack_cnt = 0;
        address = 11'h123;
        idle(11);
        build_frame(11'h123, 1'b0, 1'b0, 4'd4, 32'hDEAD_BEEF, -1);
        base = bit_idx;
        push_valid(base + eof7_rel, 11'h123, 1'b0, 4'd4, 32'hDEAD_BEEF);
        send_fq();
        idle(1);
        address = 11'h5AA;
        build_frame(11'h5AA, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, -1);
        base = bit_idx;
        push_valid(base + eof7_rel, 11'h5AA, 1'b0, 4'd0, 32'h0);
        send_fq();
        idle(4);
        total++;
        if (ack_cnt != 2) begin
            bad++; $display("FAIL b2b_ack got=%0d required=2", ack_cnt);
        end
        check_drained("b2b");
    endtask

    task automatic test_stuff_error();
        int base;
        ack_cnt = 0; busy_cnt = 0;
        idle(11);
        base = bit_idx;
        push_error(base + 5, 3'd1);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        idle(4);
        send_bit(1'b0);
        idle(4);
        total++;
        if (busy_cnt != 5 || ack_cnt != 0) begin
            bad++; $display("FAIL stuff_busy_ack got busy=%0d ack=%0d required busy=5 ack=0",
                            busy_cnt, ack_cnt);
        end
        check_drained("stuff");
    endtask

    task automatic test_crc_error();
        int base;
        ack_cnt = 0;
        address = 11'h025;
        idle(11);
        build_frame(11'h025, 1'b0, 1'b0, 4'd2, 32'hA53C_0000, 19);
        base = bit_idx;
        push_error(base + delim_rel, 3'd3);
        send_fq();
        idle(4);
        total++;
        if (ack_cnt != 0) begin
            bad++; $display("FAIL crc_ack got=%0d required=0", ack_cnt);
        end
        check_drained("crc");
    endtask

    task automatic test_form_errors();
        int base;
        ack_cnt = 0;
        address = 11'h301;
        idle(11);
        build_frame(11'h301, 1'b0, 1'b0, 4'd1, 32'h7E00_0000, -1);
        fq[eof1_rel + 2] = 1'b0;
        base = bit_idx;
        push_error(base + eof1_rel + 2, 3'd2);
        send_fq();
        idle(2);
        total++;
        if (ack_cnt != 1) begin
            bad++; $display("FAIL eof_form_ack got=%0d required=1", ack_cnt);
        end
        idle(11);
        build_frame(11'h301, 1'b0, 1'b0, 4'd5, 32'h0, -1);
        base = bit_idx;
        push_error(base + map[18], 3'd2);
        send_fq();
        idle(11);
        build_frame(11'h301, 1'b0, 1'b1, 4'd1, 32'h1100_0000, -1);
        base = bit_idx;
        push_error(base + map[13], 3'd4);
        send_fq();
        idle(6);
        total++;
        if (rx.error_code !== 3'd4 || rx.rx_id !== last_id) begin
            bad++; $display("FAIL error_hold got code=%0d id=%h required code=4 id=%h",
                            rx.error_code, rx.rx_id, last_id);
        end
        check_drained("form");
    endtask

    task automatic test_filter();
        ack_cnt = 0;
        address = 11'h025;
        idle(11);
        build_frame(11'h026, 1'b0, 1'b0, 4'd2, 32'hA53C_0000, -1);
        send_fq();
        idle(4);
        total++;
        if (ack_cnt != 0 || rx.rx_id !== last_id) begin
            bad++; $display("FAIL filter got ack=%0d id=%h required ack=0 id=%h",
                            ack_cnt, rx.rx_id, last_id);
        end
        check_drained("filter");
    endtask

    task automatic test_reset_mid_frame();
        int cut;
        address = 11'h025;
        idle(11);
        build_frame(11'h025, 1'b0, 1'b0, 4'd4, 32'h0F1E_2D3C, -1);
        cut = map[30];
        for (int i = 0; i < cut; i++) send_bit(fq[i]);
        total++;
        if (rx.busy !== 1'b1) begin
            bad++; $display("FAIL midrst_busy_before got=%0b required=1", rx.busy);
        end
        RESET = 1'b1;
        send_bit(fq[cut]);
        RESET = 1'b0;
        total++;
        if ({rx.rx_id, rx.rx_dlc, rx.rx_data, rx.error_code, rx.busy, rx.ack_out,
             rx.rx_valid, rx.rx_error} !== 54'h0) begin
            bad++; $display("FAIL midrst_outputs got id=%h data=%h code=%0d busy=%0b required 0",
                            rx.rx_id, rx.rx_data, rx.error_code, rx.busy);
        end
        last_id = 11'h0; last_rtr = 1'b0; last_dlc = 4'h0; last_data = 32'h0;
        ack_cnt = 0;
        for (int i = cut + 1; i < fq.size(); i++) send_bit(fq[i]);
        idle(4);
        total++;
        if (ack_cnt != 0) begin
            bad++; $display("FAIL midrst_ack got=%0d required=0", ack_cnt);
        end
        check_drained("midrst");
    endtask

    initial begin
        test_reset();
        test_integration();
        test_good_frame();
        test_back_to_back();
        test_stuff_error();
        test_crc_error();
        test_form_errors();
`ifdef CAN_RX_FILTER_EN
        test_filter();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
